// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI master stage feeding the SPI slave + single-port RAM. It takes 10-bit
//   commands over a valid/ready handshake and serialises each one MSB first
//   inside a single SS_n low window. For read-data commands it waits a fixed
//   turnaround and then shifts in one MISO byte. The SPI bit clock is clk
//   itself, so master and slave share it.
//
// Parameters
//   READ_LATENCY  cycles between the last MOSI command bit and the first MISO bit (1..7)
//   GAP_CYCLES    cycles SS_n is held high after each frame (>=1)
//
// Ports
//   clk        system/SPI clock, rising edge
//   rst        synchronous reset, active-high
//   cmd_valid  command present
//   cmd_data   [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload
//   cmd_ready  master idle, command can be accepted
//   SS_n       slave select, active-low
//   MOSI       serial data to the slave
//   MISO       serial data from the slave
//   rd_data    last captured read byte
//   rd_valid   one-cycle pulse when rd_data is updated
//   seq_err    (SPI_MASTER_SEQ_CHK_EN only) pulse when a rd-data command
//              arrives without a preceding rd-addr
//
// Build option
//   SPI_MASTER_SEQ_CHK_EN  enables the rd-addr/rd-data sequence check.
module spi_master_ctrl #(
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_data,
  output logic       cmd_ready,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid
`ifdef SPI_MASTER_SEQ_CHK_EN
  ,
  output logic       seq_err
`endif
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    SHIFT,
    TURN,
    CAPTURE,
    GAP
  } state_t;

  state_t        state;
  logic [9:0]    cmd_q;
  logic [1:0]    op_q;
  logic [3:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    rd_shift;
  logic          seq_reject;

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic addr_armed;

  // A rd-data command is only legal once a rd-addr has armed the slave.
  assign seq_reject = (cmd_data[9:8] == 2'b11) && !addr_armed;
`else
  assign seq_reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      cmd_q     <= 10'h000;
      op_q      <= 2'b00;
      bit_cnt   <= 4'd0;
      gap_cnt   <= '0;
      rd_shift  <= 8'h00;
`ifdef SPI_MASTER_SEQ_CHK_EN
      addr_armed <= 1'b0;
      seq_err    <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHK_EN
      seq_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            // A rejected command still drops cmd_ready for one cycle so the
            // upstream sees a normal one-shot acceptance.
            cmd_ready <= 1'b0;
            if (seq_reject) begin
`ifdef SPI_MASTER_SEQ_CHK_EN
              seq_err <= 1'b1;
`endif
            end else begin
              cmd_q <= cmd_data;
              op_q  <= cmd_data[9:8];
              SS_n  <= 1'b0;
              state <= START;
`ifdef SPI_MASTER_SEQ_CHK_EN
              if (cmd_data[9:8] == 2'b10) addr_armed <= 1'b1;
              else if (cmd_data[9:8] == 2'b11) addr_armed <= 1'b0;
`endif
            end
          end
        end

        START: begin
          // Command-type bit announces read/write to the slave.
          MOSI  <= cmd_q[9];
          state <= CMD;
        end

        CMD: begin
          // cmd_q is shifted left so cmd_q[9] always holds the next bit.
          MOSI    <= cmd_q[9];
          cmd_q   <= {cmd_q[8:0], 1'b0};
          bit_cnt <= 4'd0;
          state   <= SHIFT;
        end

        SHIFT: begin
          if (bit_cnt == 4'd9) begin
            MOSI    <= 1'b0;
            bit_cnt <= 4'd0;
            gap_cnt <= '0;
            if (op_q == 2'b11) begin
              state <= TURN;
            end else begin
              SS_n  <= 1'b1;
              state <= GAP;
            end
          end else begin
            MOSI    <= cmd_q[9];
            cmd_q   <= {cmd_q[8:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        TURN: begin
          if (bit_cnt == 4'(READ_LATENCY - 1)) begin
            bit_cnt <= 4'd0;
            state   <= CAPTURE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        CAPTURE: begin
          rd_shift <= {rd_shift[6:0], MISO};
          if (bit_cnt == 4'd7) begin
            // Publish the byte including the bit sampled on this edge.
            rd_data  <= {rd_shift[6:0], MISO};
            rd_valid <= 1'b1;
            SS_n     <= 1'b1;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
//   Directed self-checking bench for spi_master_ctrl with default parameters.
//   Outputs are sampled 1 time unit after each rising edge; sample k of a
//   frame is the one taken just after the accept edge + k. Expected frame
//   waveforms come from a small timing model of the frame format.
module tb_spi_master_ctrl;

  localparam int RL  = 2;
  localparam int GAP = 1;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rd_data;
  logic       rd_valid;
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic       seq_err;
`endif

  int errors = 0;
  int checks = 0;
  int rdv_cnt = 0;
  int seq_cnt = 0;

  // Recorded frame samples, packed as {SS_n, MOSI, cmd_ready, rd_valid}.
  logic [3:0] rec [0:63];
  int         rec_n;

  spi_master_ctrl #(
    .READ_LATENCY(RL),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef SPI_MASTER_SEQ_CHK_EN
    ,
    .seq_err  (seq_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) rdv_cnt++;
`ifdef SPI_MASTER_SEQ_CHK_EN
    if (seq_err === 1'b1) seq_cnt++;
`endif
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame model: expected output at sample k after accepting command c.
  function automatic logic m_ss(input logic [9:0] c, input int k);
    int low_end;
    low_end = (c[9:8] == 2'b11) ? 19 + RL : 11;
    return (k > low_end);
  endfunction

  function automatic logic m_mosi(input logic [9:0] c, input int k);
    logic [9:0] t;
    if (k == 1) return c[9];
    if (k >= 2 && k <= 11) begin
      t = c << (k - 2);
      return t[9];
    end
    return 1'b0;
  endfunction

  function automatic logic m_ready(input logic [9:0] c, input int k);
    return (k >= ((c[9:8] == 2'b11) ? 20 + RL + GAP : 12 + GAP));
  endfunction

  function automatic logic m_rdv(input logic [9:0] c, input int k);
    return (c[9:8] == 2'b11) && (k == 20 + RL);
  endfunction

  function automatic logic [3:0] m_frame(input logic [9:0] c, input int k);
    return {m_ss(c, k), m_mosi(c, k), m_ready(c, k), m_rdv(c, k)};
  endfunction

  // Waits (bounded) for cmd_ready, issues one command, then records nsamp
  // samples. The slave's MISO byte mb is driven in the capture window.
  // busy_k injects a 1-cycle cmd_valid of 10'h1FF; rst_k asserts rst for one edge.
  task automatic applyStimulus(input logic [9:0] c, input logic [7:0] mb,
                               input int nsamp, input int busy_k, input int rst_k);
    int w;
    logic [7:0] mt;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_wait cmd_ready=%b required 1 within %0d cycles", cmd_ready, w);
    end
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < nsamp; k++) begin
      rec[k] = {ss_n, mosi, cmd_ready, rd_valid};
      if (k >= 12 + RL && k <= 19 + RL) begin
        mt   = mb << (k - 12 - RL);
        miso = mt[7];
      end else begin
        miso = 1'b0;
      end
      if (k == busy_k) begin
        cmd_valid = 1'b1;
        cmd_data  = 10'h1FF;
      end else if (k == busy_k + 1) begin
        cmd_valid = 1'b0;
      end
      if (k == rst_k) rst = 1'b1;
      else if (k == rst_k + 1) rst = 1'b0;
      if (k < nsamp - 1) begin
        @(posedge clk); #1;
      end
    end
    rec_n = nsamp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 10'h000;
    miso = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ss_n, mosi, cmd_ready, rd_valid} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL reset_ctrl {ss,mosi,ready,rdv} got=%b req=1010", {ss_n, mosi, cmd_ready, rd_valid});
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_rd_data got=%h req=00", rd_data);
    end
`ifdef SPI_MASTER_SEQ_CHK_EN
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_seq_err got=%b req=0", seq_err);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ss_n, mosi, cmd_ready, rd_valid} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL idle_after_reset {ss,mosi,ready,rdv} got=%b req=1010", {ss_n, mosi, cmd_ready, rd_valid});
    end
  endtask

  task automatic test_write_addr();
    int base;
    logic [3:0] e;
    base = rdv_cnt;
    applyStimulus(10'h0A5, 8'h00, 14, -1, -1);
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h0A5, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL write_addr k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    checks++;
    if (rdv_cnt != base) begin
      errors++;
      $display("[TB] FAIL write_addr_rdv pulses got=%0d req=0", rdv_cnt - base);
    end
  endtask

  task automatic test_read_seq();
    int base;
    int lat;
    logic [3:0] e;
    base = rdv_cnt;
    applyStimulus(10'h23C, 8'h00, 14, -1, -1);
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h23C, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL rd_addr k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    applyStimulus(10'h300, 8'hC3, 24, -1, -1);
    lat = -1;
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h300, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL rd_data_frame k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
      if (lat < 0 && rec[k][1] === 1'b1) lat = k;
    end
    checks++;
    if (lat != 23) begin
      errors++;
      $display("[TB] FAIL rd_latency accept_to_ready got=%0d req=23", lat);
    end
    checks++;
    if (rd_data !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL rd_data got=%h req=c3", rd_data);
    end
    checks++;
    if (rdv_cnt - base != 1) begin
      errors++;
      $display("[TB] FAIL rd_valid_pulses got=%0d req=1", rdv_cnt - base);
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] e;
    applyStimulus(10'h15A, 8'h00, 14, 5, -1);
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h15A, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL busy_frame k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ss_n, cmd_ready} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL busy_not_queued i=%0d {ss,ready} got=%b req=11", i, {ss_n, cmd_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] cmds [0:2];
    int acc [0:2];
    logic [3:0] r [0:63];
    logic will_acc;
    logic prev;
    int idx;
    int falls;
    logic [3:0] e;
    cmds[0] = 10'h011;
    cmds[1] = 10'h1A2;
    cmds[2] = 10'h0F3;
    for (int i = 0; i < 3; i++) acc[i] = -100;
    idx = 0;
    cmd_valid = 1'b1;
    cmd_data  = cmds[0];
    for (int c = 0; c < 60; c++) begin
      will_acc = (cmd_ready === 1'b1) && cmd_valid;
      @(posedge clk); #1;
      r[c] = {ss_n, mosi, cmd_ready, rd_valid};
      if (will_acc) begin
        if (idx < 3) acc[idx] = c;
        idx++;
        if (idx < 3) cmd_data = cmds[idx];
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("[TB] FAIL b2b_accepts got=%0d req=3", idx);
    end
    falls = 0;
    prev = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (prev === 1'b1 && r[c][3] === 1'b0) falls++;
      prev = r[c][3];
    end
    checks++;
    if (falls != 3) begin
      errors++;
      $display("[TB] FAIL b2b_frames SS_n low windows got=%0d req=3", falls);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 14) begin
        errors++;
        $display("[TB] FAIL b2b_spacing frame=%0d got=%0d req=14", i, acc[i] - acc[i-1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (acc[i] >= 0) begin
        for (int k = 0; k < 14; k++) begin
          e = m_frame(cmds[i], k);
          e[1] = (k == 13);
          checks++;
          if (r[acc[i] + k] !== e) begin
            errors++;
            $display("[TB] FAIL b2b frame=%0d k=%0d {ss,mosi,ready,rdv} got=%b req=%b", i, k, r[acc[i] + k], e);
          end
        end
      end
    end
    checks++;
    if (rd_data !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL rd_data_hold got=%h req=c3", rd_data);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [3:0] e;
    base = rdv_cnt;
    applyStimulus(10'h1C3, 8'h00, 9, -1, 7);
    for (int k = 0; k < 8; k++) begin
      e = m_frame(10'h1C3, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL pre_reset k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    checks++;
    if (rec[8] !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL midframe_reset {ss,mosi,ready,rdv} got=%b req=1010", rec[8]);
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midframe_reset_rd_data got=%h req=00", rd_data);
    end
    applyStimulus(10'h25A, 8'h00, 14, -1, -1);
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h25A, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL post_reset k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    checks++;
    if (rdv_cnt != base) begin
      errors++;
      $display("[TB] FAIL midframe_rdv pulses got=%0d req=0", rdv_cnt - base);
    end
  endtask

`ifdef SPI_MASTER_SEQ_CHK_EN
  task automatic test_seq_chk();
    int base;
    logic [3:0] e;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 10'h300;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if ({seq_err, ss_n, cmd_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL seq_reject {seq_err,ss,ready} got=%b req=110", {seq_err, ss_n, cmd_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({seq_err, ss_n, cmd_ready} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL seq_recover {seq_err,ss,ready} got=%b req=011", {seq_err, ss_n, cmd_ready});
    end
    base = seq_cnt;
    applyStimulus(10'h210, 8'h00, 14, -1, -1);
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h210, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL seq_rd_addr k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    applyStimulus(10'h300, 8'h5A, 24, -1, -1);
    for (int k = 0; k < rec_n; k++) begin
      e = m_frame(10'h300, k);
      checks++;
      if (rec[k] !== e) begin
        errors++;
        $display("[TB] FAIL seq_rd_data k=%0d {ss,mosi,ready,rdv} got=%b req=%b", k, rec[k], e);
      end
    end
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL seq_rd_value got=%h req=5a", rd_data);
    end
    checks++;
    if (seq_cnt != base) begin
      errors++;
      $display("[TB] FAIL seq_err_quiet pulses got=%0d req=0", seq_cnt - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_addr();
    test_read_seq();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
`ifdef SPI_MASTER_SEQ_CHK_EN
    test_seq_chk();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
